// File: rtl/sentinel_pkg.sv
// Shared constants and types for the Sentinel lock initiator.
//   SEG_* / STATUS_*  : display and status codes the lock can present
//   SENTINEL_KEY      : key the lock accepts
//   resp_class_t      : classification of a synchronized (seg, status) pair
//   init_state_t      : initiator FSM states
//   classify()        : maps a (seg, status) pair onto resp_class_t
package sentinel_pkg;
  localparam logic [7:0] SEG_LOCKED   = 8'hC7;
  localparam logic [7:0] SEG_VERIFIED = 8'hC1;
  localparam logic [7:0] SEG_OFF      = 8'hFF;
  localparam logic [7:0] STATUS_GLOW  = 8'hFF;
  localparam logic [7:0] STATUS_DARK  = 8'h00;
  localparam logic [7:0] SENTINEL_KEY = 8'hB6;

  typedef enum logic [1:0] {VER, LOCK, OFF, BAD} resp_class_t;

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, REPORT, LOCKOUT} init_state_t;

  function automatic resp_class_t classify(input logic [7:0] seg, input logic [7:0] status);
    if (seg == SEG_VERIFIED && status == STATUS_GLOW) return VER;
    if (seg == SEG_LOCKED   && status == STATUS_DARK) return LOCK;
    if (seg == SEG_OFF      && status == STATUS_DARK) return OFF;
    return BAD;
  endfunction
endpackage

// File: rtl/sentinel_auth_initiator_if.sv
// Bundle between a controller and the Sentinel initiator.
//   master : controller side (drives start/key_in/clear_lockout and the lock response)
//   slave  : initiator side (drives key toward the lock and the attempt status)
interface sentinel_auth_initiator_if #(parameter int MAX_FAILS = 3);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic           start;
  logic [7:0]     key_in;
  logic           clear_lockout;
  logic [7:0]     seg_in;
  logic [7:0]     status_in;
  logic [7:0]     key_out;
  logic           key_valid;
  logic           busy;
  logic           done;
  logic           pass;
  logic           fault;
  logic           lockout;
  logic [FCW-1:0] fail_count;

  modport master (
    output start, key_in, clear_lockout, seg_in, status_in,
    input  key_out, key_valid, busy, done, pass, fault, lockout, fail_count
  );

  modport slave (
    input  start, key_in, clear_lockout, seg_in, status_in,
    output key_out, key_valid, busy, done, pass, fault, lockout, fail_count
  );
endinterface

// File: rtl/sentinel_resp_sync.sv
// Brings the lock's display and status buses into the clk domain through
// 2-flop synchronizers and classifies the synchronized pair every cycle.
//   clk, rst   : clock, async active-high reset
//   seg_in     : lock display code (async)
//   status_in  : lock status array (async)
//   cls        : classification of the synchronized pair
module sentinel_resp_sync
  import sentinel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  status_in,
  output resp_class_t cls
);
  logic [1:0][7:0] seg_pipe, st_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_pipe <= '0;
      st_pipe  <= '0;
    end else begin
      seg_pipe <= {seg_pipe[0], seg_in};
      st_pipe  <= {st_pipe[0], status_in};
    end
  end

  assign cls = classify(seg_pipe[1], st_pipe[1]);
endmodule

// File: rtl/sentinel_auth_initiator.sv
// Initiator for the Sentinel lock port: drives a captured key, waits for the
// lock to settle, confirms a stable VER/LOCK response (or times out), reports
// the result and enforces a failed-attempt lockout.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sentinel_auth_initiator_if (control, key, response, status)
module sentinel_auth_initiator
  import sentinel_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int CONFIRM_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_FAILS      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  sentinel_auth_initiator_if.slave bus
);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int SW  = $clog2(SETTLE_CYCLES) + 1;
  localparam int CW  = $clog2(CONFIRM_CYCLES) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  init_state_t    state, nstate;
  resp_class_t    cls, prev_cls;
  logic [7:0]     key_q;
  logic [SW-1:0]  settle_cnt;
  logic [CW-1:0]  conf_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [FCW-1:0] fail_q, fail_inc;
  logic           pass_q, fault_q;
  logic           conf_hit, conf_last, tmo_last;

  sentinel_resp_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (bus.seg_in),
    .status_in (bus.status_in),
    .cls       (cls)
  );

  // A hit is a valid verdict matching the previous cycle's; the last hit
  // accepts the result. Confirmation wins over timeout in the same cycle.
  assign conf_hit  = (cls == VER || cls == LOCK) && (cls == prev_cls);
  assign conf_last = conf_hit && (conf_cnt == CW'(CONFIRM_CYCLES - 1));
  assign tmo_last  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fail_inc  = (fail_q == FCW'(MAX_FAILS)) ? fail_q : fail_q + 1'b1;

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (bus.start) nstate = DRIVE;
      DRIVE:   if (settle_cnt == SW'(SETTLE_CYCLES - 1)) nstate = SAMPLE;
      SAMPLE:  if (conf_last || tmo_last) nstate = REPORT;
      REPORT:  nstate = (fail_q == FCW'(MAX_FAILS)) ? LOCKOUT : IDLE;
      LOCKOUT: if (bus.clear_lockout) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_cls   <= BAD;
      key_q      <= '0;
      settle_cnt <= '0;
      conf_cnt   <= '0;
      tmo_cnt    <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state    <= nstate;
      prev_cls <= cls;
      case (state)
        IDLE: if (bus.start) begin
          key_q      <= bus.key_in;
          pass_q     <= 1'b0;
          fault_q    <= 1'b0;
          settle_cnt <= '0;
        end
        DRIVE: begin
          settle_cnt <= settle_cnt + 1'b1;
          conf_cnt   <= '0;
          tmo_cnt    <= '0;
        end
        SAMPLE: begin
          tmo_cnt  <= tmo_cnt + 1'b1;
          conf_cnt <= conf_hit ? conf_cnt + 1'b1 : '0;
          // Result registers load on entry to REPORT so they are valid with done.
          if (conf_last) begin
            pass_q <= (cls == VER);
            fail_q <= (cls == VER) ? '0 : fail_inc;
          end else if (tmo_last) begin
            fault_q <= 1'b1;
            fail_q  <= fail_inc;
          end
        end
        LOCKOUT: if (bus.clear_lockout) fail_q <= '0;
        default: ;
      endcase
    end
  end

  // Status outputs decode the state register so reset clears them at once.
  assign bus.key_valid  = (state == DRIVE) || (state == SAMPLE);
  assign bus.key_out    = bus.key_valid ? key_q : 8'h00;
  assign bus.busy       = bus.key_valid || (state == REPORT);
  assign bus.done       = (state == REPORT);
  assign bus.lockout    = (state == LOCKOUT);
  assign bus.pass       = pass_q;
  assign bus.fault      = fault_q;
  assign bus.fail_count = fail_q;
endmodule

// File: tb/tb_sentinel_auth_initiator.sv
module tb_sentinel_auth_initiator;
  import sentinel_pkg::*;

  logic clk, rst;
  int   n_chk, n_fail;
  time  t_start;
  int   lat;

  sentinel_auth_initiator_if #(.MAX_FAILS(3)) bus ();

  sentinel_auth_initiator dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_resp(input logic [7:0] seg, input logic [7:0] st);
    bus.seg_in    = seg;
    bus.status_in = st;
  endtask

  // Start accepted at the posedge P0; returns at P0+1.
  task automatic start_attempt(input logic [7:0] k);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = k;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t_start   = $time;
  endtask

  // Waits (bounded) for done; lat = clock edges from P0 to the REPORT cycle.
  task automatic wait_done(input string tag, output int l);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, bus.done, 1);
    l = int'(($time - t_start) / 10);
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1;
    bus.start = 0; bus.key_in = 0; bus.clear_lockout = 0;
    set_resp(SEG_OFF, STATUS_DARK);
    #1;
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_lockout", bus.lockout, 0);
    chk("rst_fail_count", bus.fail_count, 0);
    chk("rst_key_out", bus.key_out, 0);
    gap(2);
    @(negedge clk); rst = 0;
    gap(3);

    // VER one cycle after the drive begins
    start_attempt(SENTINEL_KEY);
    chk("ver_key_valid", bus.key_valid, 1);
    chk("ver_key_out", bus.key_out, 8'hB6);
    chk("ver_busy", bus.busy, 1);
    gap(1);
    set_resp(SEG_VERIFIED, STATUS_GLOW);
    wait_done("ver", lat);
    chk("ver_pass", bus.pass, 1);
    chk("ver_fault", bus.fault, 0);
    chk("ver_fail_count", bus.fail_count, 0);
    chk("ver_report_key_out", bus.key_out, 0);
    chk("ver_report_key_valid", bus.key_valid, 0);
    chk("ver_report_busy", bus.busy, 1);
    gap(1);
    chk("ver_idle_done", bus.done, 0);
    chk("ver_idle_busy", bus.busy, 0);

    // LOCK response, start accepted in the cycle right after REPORT
    set_resp(SEG_LOCKED, STATUS_DARK);
    gap(3);
    start_attempt(8'h00);
    chk("lock_pass_cleared", bus.pass, 0);
    wait_done("lock1", lat);
    chk("lock1_pass", bus.pass, 0);
    chk("lock1_fault", bus.fault, 0);
    chk("lock1_fail_count", bus.fail_count, 1);
    gap(1);
    start_attempt(8'h00);
    chk("b2b_start_key_valid", bus.key_valid, 1);
    wait_done("lock2", lat);
    chk("lock2_fail_count", bus.fail_count, 2);
    gap(1);
    start_attempt(8'h11);
    wait_done("lock3", lat);
    chk("lock3_fail_count", bus.fail_count, 3);
    gap(1);
    chk("lockout_set", bus.lockout, 1);
    chk("lockout_busy", bus.busy, 0);

    // start ignored in LOCKOUT
    start_attempt(SENTINEL_KEY);
    chk("lockout_start_ignored", bus.key_valid, 0);
    gap(2);
    chk("lockout_held", bus.lockout, 1);
    chk("lockout_fail_count", bus.fail_count, 3);

    // clear and start together: clear wins
    @(negedge clk);
    bus.clear_lockout = 1; bus.start = 1;
    @(posedge clk); #1;
    bus.clear_lockout = 0; bus.start = 0;
    chk("clear_lockout_low", bus.lockout, 0);
    chk("clear_fail_count", bus.fail_count, 0);
    gap(1);
    chk("clear_start_dropped", bus.key_valid, 0);

    // BAD for the whole window: timeout
    set_resp(SEG_VERIFIED, STATUS_DARK);
    gap(3);
    start_attempt(SENTINEL_KEY);
    wait_done("bad", lat);
    chk("bad_latency", lat, 20);
    chk("bad_fault", bus.fault, 1);
    chk("bad_pass", bus.pass, 0);
    chk("bad_fail_count", bus.fail_count, 1);

    // Stable VER before start: minimum latency
    set_resp(SEG_VERIFIED, STATUS_GLOW);
    gap(4);
    start_attempt(SENTINEL_KEY);
    chk("fault_cleared", bus.fault, 0);
    wait_done("stable", lat);
    chk("stable_latency", lat, 7);
    chk("stable_pass", bus.pass, 1);
    chk("stable_fail_count", bus.fail_count, 0);

    // VER/LOCK toggling for 10 cycles, then VER held
    set_resp(SEG_LOCKED, STATUS_DARK);
    gap(4);
    start_attempt(SENTINEL_KEY);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 2 == 0) set_resp(SEG_VERIFIED, STATUS_GLOW);
      else            set_resp(SEG_LOCKED, STATUS_DARK);
    end
    @(negedge clk);
    set_resp(SEG_VERIFIED, STATUS_GLOW);
    wait_done("toggle", lat);
    chk("toggle_latency", lat, 16);
    chk("toggle_pass", bus.pass, 1);
    chk("toggle_fault", bus.fault, 0);

    // Async reset in DRIVE with a nonzero fail_count
    set_resp(SEG_LOCKED, STATUS_DARK);
    gap(4);
    start_attempt(8'h22);
    wait_done("prerst", lat);
    chk("prerst_fail_count", bus.fail_count, 1);
    gap(1);
    start_attempt(8'h33);
    gap(1);
    #2;
    rst = 1;
    #1;
    chk("arst_key_valid", bus.key_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_fail_count", bus.fail_count, 0);
    chk("arst_key_out", bus.key_out, 0);
    @(negedge clk); rst = 0;
    set_resp(SEG_VERIFIED, STATUS_GLOW);
    gap(4);
    start_attempt(SENTINEL_KEY);
    wait_done("postrst", lat);
    chk("postrst_latency", lat, 7);
    chk("postrst_pass", bus.pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sentinel_auth_initiator.md
# sentinel_auth_initiator

Initiator side of the Sentinel lock port. It presents an 8-bit candidate key to a Sentinel lock and reads back the lock's 7-segment code and status array. It then classifies the response as verified, locked or fault, and enforces a failed-attempt lockout. The block sits in bench/controller silicon or an FPGA harness that drives the lock's key DIP inputs and reads its display and status outputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles the key is held before response sampling begins (≥1).
- `CONFIRM_CYCLES`, 3: consecutive identical valid classifications needed to accept a result (≥1).
- `TIMEOUT_CYCLES`, 16: maximum cycles in SAMPLE before a fault is declared (> CONFIRM_CYCLES).
- `MAX_FAILS`, 3: failed attempts that trigger lockout (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  attempt request; sampled only in IDLE.
- `key_in`  in  8  candidate key, captured on the accepted `start`.
- `clear_lockout`  in  1  exits LOCKOUT and zeroes `fail_count`.
- `seg_in`  in  8  lock display code, asynchronous to `clk`.
- `status_in`  in  8  lock status array, asynchronous to `clk`.
- `key_out`  out  8  key driven toward the lock; 0x00 when not driving.
- `key_valid`  out  1  key drive enable.
- `busy`  out  1  attempt in progress.
- `done`  out  1  one-cycle pulse when an attempt completes.
- `pass`  out  1  last attempt verified; held until the next accepted `start`.
- `fault`  out  1  last attempt had an inconsistent or absent response; held like `pass`.
- `lockout`  out  1  high while in LOCKOUT.
- `fail_count`  out  `$clog2(MAX_FAILS+1)`  count of failed attempts, saturating.

## Operation
- Input path: `seg_in` and `status_in` each pass through a 2-flop synchronizer. The synchronized pair is classified every cycle:
  - VER: seg 0xC1 and status 0xFF.
  - LOCK: seg 0xC7 and status 0x00.
  - OFF: seg 0xFF and status 0x00.
  - BAD: any other combination.
- IDLE:
  - `start` with `lockout` low captures `key_in`. Next state is DRIVE.
  - `start` in any other state is ignored.
- DRIVE:
  - `key_out` shows the captured key, `key_valid` is 1, `busy` is 1.
  - Stays for exactly SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE:
  - Each cycle, a VER or LOCK classification equal to the previous cycle's increments the confirm counter. Any change, OFF or BAD resets the counter to 0.
  - Counter reaching CONFIRM_CYCLES: result is VER or LOCK, next state is REPORT.
  - TIMEOUT_CYCLES elapsed without confirmation: result is FAULT, next state is REPORT.
- REPORT (1 cycle):
  - `done`=1. `pass` and `fault` are updated. `key_valid` goes to 0 and `key_out` to 0x00.
  - VER: `fail_count` cleared to 0.
  - LOCK or FAULT: `fail_count` increments, saturating at MAX_FAILS.
  - Next state is LOCKOUT if `fail_count` reaches MAX_FAILS, otherwise IDLE.
- LOCKOUT:
  - `lockout`=1 and `busy`=0.
  - `clear_lockout` zeroes `fail_count` and returns to IDLE on the next cycle.
  - `clear_lockout` outside LOCKOUT has no effect.
- Simultaneous `start` and `clear_lockout` in LOCKOUT: the clear wins and the start is dropped.
- Reset is asynchronous at any point, including mid-attempt. All outputs go to reset values immediately: `key_out` 0x00, and `key_valid`, `busy`, `done`, `pass`, `fault`, `lockout` and `fail_count` all 0. State returns to IDLE and the synchronizers clear.

## Timing
- `start` is high in cycle T.
- `key_valid` rises at T+1.
- SAMPLE begins at T+1+SETTLE_CYCLES.
- A stable response yields `done` at the earliest at T+2+SETTLE_CYCLES+CONFIRM_CYCLES−1.
  - This count excludes the 2-cycle synchronizer delay for responses that change after the drive begins.
- A timeout yields `done` at T+2+SETTLE_CYCLES+TIMEOUT_CYCLES−1.
- `busy` is high from T+1 through the REPORT cycle inclusive.
- A `start` in the cycle after REPORT is accepted.
- `pass` and `fault` are never both 1. Both clear at T+1 of the next accepted `start`.

## Structure
- Package `sentinel_pkg` holds:
  - Constants SEG_LOCKED=0xC7, SEG_VERIFIED=0xC1, SEG_OFF=0xFF, STATUS_GLOW=0xFF, STATUS_DARK=0x00, SENTINEL_KEY=0xB6.
  - Enum `resp_class_t` {VER, LOCK, OFF, BAD}.
  - FSM enum `init_state_t` {IDLE, DRIVE, SAMPLE, REPORT, LOCKOUT}.
- Sub-module `sentinel_resp_sync`: 2-flop synchronizers plus the classifier, with output `resp_class_t`.
- The top level holds the FSM, counters and output registers.

## Test plan
All scenarios use default parameters.
- Key 0xB6, model responds VER after 1 cycle: `done` fires, `pass`=1, `fault`=0, `fail_count`=0, `key_out` returns to 0x00.
- Key 0x00, model responds LOCK: `pass`=0, `fault`=0, `fail_count`=1.
- Three LOCK attempts: `fail_count`=3 and `lockout`=1. A fourth `start` is ignored (`key_valid` stays 0). `clear_lockout` gives IDLE with `fail_count`=0.
- Model drives seg 0xC1 with status 0x00 (BAD) for the whole window: `done` at T+21, `fault`=1, `fail_count` increments.
- Response toggles VER/LOCK every cycle for 10 cycles, then holds VER: the confirm counter keeps restarting, final result is `pass`=1 before timeout.
- `rst` asserted during DRIVE: `key_valid` and `busy` drop to 0 asynchronously without waiting for a clock edge, `fail_count`=0. A new `start` after reset completes normally.
